// File: rtl/sram_wait_adapter.sv
// sram_wait_adapter
// Stall generator between CPU pipeline channels and synchronous SRAM ports.
// Each channel runs a small FSM that holds its pipeline stall for exactly
// RD_LAT or WR_LAT cycles per access, then pulses done for one cycle.
// With SHARED=1 all channels contend for one port; the highest index wins.
//
// Per-channel FSM states:
//   state  | meaning
//   IDLE   | no access in flight; a request here accepts if the port is free
//   WAIT   | access in flight, counter running down, port held, stall high
//   DONE   | one-cycle completion: done=1, stall=0, port released this cycle
module sram_wait_adapter #(
  parameter int CH     = 2,
  parameter int LAT_W  = 3,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1,
  parameter int SHARED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] req,
  input  logic [CH-1:0] we,
  output logic [CH-1:0] stall,
  output logic [CH-1:0] grant,
  output logic [CH-1:0] done,
  output logic          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [LAT_W-1:0] RD_LAT_V = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0] WR_LAT_V = LAT_W'(WR_LAT);
  localparam logic [LAT_W-1:0] ONE_V    = LAT_W'(1);

  logic [CH-1:0] w_idle;
  logic [CH-1:0] w_wait;
  logic [CH-1:0] w_done;
  logic [CH-1:0] w_port_free;
  logic [CH-1:0] w_accept;

  generate
    if (SHARED != 0) begin : g_shared
      // One port: free only when nobody holds it in WAIT and no higher-index
      // channel is taking it this cycle. DONE channels do not hold the port.
      always_comb begin
        logic v_higher;
        v_higher    = 1'b0;
        w_port_free = '0;
        for (int i = CH - 1; i >= 0; i--) begin
          w_port_free[i] = ~(|w_wait) & ~v_higher;
          v_higher       = v_higher | (req[i] & w_idle[i]);
        end
      end
    end else begin : g_indep
      // Independent ports: every channel always has its own port.
      always_comb begin
        w_port_free = '1;
      end
    end
  endgenerate

  // No access may start while reset is held, so accept is gated by rst.
  assign w_accept = req & w_idle & w_port_free & {CH{rst}};

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [1:0]       r_state;
      logic [LAT_W-1:0] r_cnt;
      logic [LAT_W-1:0] w_lat;

      assign w_lat      = we[gi] ? WR_LAT_V : RD_LAT_V;
      assign w_idle[gi] = (r_state == S_IDLE);
      assign w_wait[gi] = (r_state == S_WAIT);
      assign w_done[gi] = (r_state == S_DONE);

      // Access sequencer: accept loads lat-1, WAIT counts down to 1, DONE
      // lasts one cycle. The counter never decrements below zero.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_accept[gi]) begin
                r_cnt   <= w_lat - ONE_V;
                r_state <= (w_lat == ONE_V) ? S_DONE : S_WAIT;
              end
            end
            S_WAIT: begin
              if (r_cnt != '0) begin
                r_cnt <= r_cnt - ONE_V;
              end
              if (r_cnt <= ONE_V) begin
                r_state <= S_DONE;
              end
            end
            S_DONE: begin
              r_state <= S_IDLE;
            end
            default: begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  // A requesting channel that has not been accepted yet also stalls.
  assign stall = (req & w_idle) | w_wait;
  assign grant = w_accept | w_wait;
  assign done  = w_done;
  assign busy  = |(w_wait | w_done);

endmodule

// File: tb/tb_sram_wait_adapter.sv
// Bench for sram_wait_adapter: four configurations share one stimulus
// stream; a cycle-level reference model checks every instance every cycle,
// and directed vector tables pin down the documented corner sequences.
module tb_sram_wait_adapter;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req;
  logic [1:0]      we;
  logic [3:0][1:0] stall_o;
  logic [3:0][1:0] grant_o;
  logic [3:0][1:0] done_o;
  logic [3:0]      busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  // inst0: independent, lat 1/1; inst1: independent, rd 3 / wr 2;
  // inst2: shared, rd 1 / wr 2; inst3: independent, rd 4 / wr 1
  sram_wait_adapter #(.CH(2), .LAT_W(3), .RD_LAT(1), .WR_LAT(1), .SHARED(0)) u_i0 (
    .clk(clk), .rst(rst_n), .req(req), .we(we),
    .stall(stall_o[0]), .grant(grant_o[0]), .done(done_o[0]), .busy(busy_o[0]));
  sram_wait_adapter #(.CH(2), .LAT_W(3), .RD_LAT(3), .WR_LAT(2), .SHARED(0)) u_i1 (
    .clk(clk), .rst(rst_n), .req(req), .we(we),
    .stall(stall_o[1]), .grant(grant_o[1]), .done(done_o[1]), .busy(busy_o[1]));
  sram_wait_adapter #(.CH(2), .LAT_W(3), .RD_LAT(1), .WR_LAT(2), .SHARED(1)) u_i2 (
    .clk(clk), .rst(rst_n), .req(req), .we(we),
    .stall(stall_o[2]), .grant(grant_o[2]), .done(done_o[2]), .busy(busy_o[2]));
  sram_wait_adapter #(.CH(2), .LAT_W(3), .RD_LAT(4), .WR_LAT(1), .SHARED(0)) u_i3 (
    .clk(clk), .rst(rst_n), .req(req), .we(we),
    .stall(stall_o[3]), .grant(grant_o[3]), .done(done_o[3]), .busy(busy_o[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_shared(input int k);
    return (k == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_rd(input int k);
    case (k)
      0: return 1;
      1: return 3;
      2: return 1;
      default: return 4;
    endcase
  endfunction
  function automatic int cfg_wr(input int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d at %0t: got %b expected %b", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: per channel, stall cycles still owed after this one
  // (rem) and whether this is the completion cycle (dn).
  int rem   [4][2];
  bit dn    [4][2];
  int rem_n [4][2];
  bit dn_n  [4][2];

  task automatic model_eval();
    for (int k = 0; k < 4; k++) begin
      bit         any_wait;
      bit         taken;
      logic [1:0] acc;
      logic [1:0] e_stall;
      logic [1:0] e_grant;
      logic [1:0] e_done;
      logic       e_busy;
      if (!rst_n) begin
        for (int c = 0; c < 2; c++) begin
          rem[k][c] = 0;
          dn[k][c]  = 0;
        end
      end
      any_wait = 0;
      for (int c = 0; c < 2; c++) if (rem[k][c] > 0) any_wait = 1;
      acc   = 2'b00;
      taken = 0;
      for (int c = 1; c >= 0; c--) begin
        if (rst_n && req[c] && !dn[k][c] && rem[k][c] == 0) begin
          if (cfg_shared(k) == 0) acc[c] = 1'b1;
          else if (!any_wait && !taken) begin
            acc[c] = 1'b1;
            taken  = 1;
          end
        end
      end
      e_busy = 1'b0;
      for (int c = 0; c < 2; c++) begin
        bit idle;
        idle       = !dn[k][c] && rem[k][c] == 0;
        e_stall[c] = (idle && req[c]) || rem[k][c] > 0;
        e_grant[c] = acc[c] || rem[k][c] > 0;
        e_done[c]  = dn[k][c];
        if (rem[k][c] > 0 || dn[k][c]) e_busy = 1'b1;
        if (dn[k][c]) begin
          rem_n[k][c] = 0;
          dn_n[k][c]  = 0;
        end else if (rem[k][c] > 0) begin
          rem_n[k][c] = rem[k][c] - 1;
          dn_n[k][c]  = (rem[k][c] == 1);
        end else if (acc[c]) begin
          rem_n[k][c] = (we[c] ? cfg_wr(k) : cfg_rd(k)) - 1;
          dn_n[k][c]  = (rem_n[k][c] == 0);
        end else begin
          rem_n[k][c] = 0;
          dn_n[k][c]  = 0;
        end
      end
      chk("model_stall", k, stall_o[k], e_stall);
      chk("model_grant", k, grant_o[k], e_grant);
      chk("model_done",  k, done_o[k],  e_done);
      chk("model_busy",  k, {1'b0, busy_o[k]}, {1'b0, e_busy});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 2; c++) begin
        rem[k][c] = rem_n[k][c];
        dn[k][c]  = dn_n[k][c];
      end
  endtask

  task automatic apply(input logic r, input logic [1:0] rq, input logic [1:0] w);
    @(negedge clk);
    rst_n = r;
    req   = rq;
    we    = w;
    #1;
    model_eval();
  endtask

  typedef struct {
    string      nm;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] we;
    int         inst;
    logic [1:0] e_stall;
    logic [1:0] e_grant;
    logic [1:0] e_done;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string nm, input logic r, input logic [1:0] rq,
                              input logic [1:0] w, input int k, input logic [1:0] s,
                              input logic [1:0] g, input logic [1:0] d, input logic b);
    vec_t v;
    v.nm = nm; v.rst_n = r; v.req = rq; v.we = w; v.inst = k;
    v.e_stall = s; v.e_grant = g; v.e_done = d; v.e_busy = b;
    tbl.push_back(v);
  endfunction

  initial begin
    rst_n = 1'b0;
    req   = 2'b00;
    we    = 2'b00;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 2; c++) begin
        rem[k][c] = 0; dn[k][c] = 0; rem_n[k][c] = 0; dn_n[k][c] = 0;
      end

    //   name       rst req    we     inst stall  grant  done   busy
    add("single",   0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    add("single",   1, 2'b01, 2'b00, 0, 2'b01, 2'b01, 2'b00, 0);
    add("single",   1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b01, 1);
    add("single",   1, 2'b01, 2'b00, 0, 2'b01, 2'b01, 2'b00, 0);
    add("single",   1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b01, 1);
    add("single",   1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);

    add("multi",    0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0);
    add("multi",    1, 2'b10, 2'b00, 1, 2'b10, 2'b10, 2'b00, 0);
    add("multi",    1, 2'b10, 2'b00, 1, 2'b10, 2'b10, 2'b00, 1);
    add("multi",    1, 2'b10, 2'b00, 1, 2'b10, 2'b10, 2'b00, 1);
    add("multi",    1, 2'b10, 2'b00, 1, 2'b00, 2'b00, 2'b10, 1);
    add("multi",    1, 2'b10, 2'b10, 1, 2'b10, 2'b10, 2'b00, 0);
    add("multi",    1, 2'b10, 2'b00, 1, 2'b10, 2'b10, 2'b00, 1);
    add("multi",    1, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b10, 1);
    add("multi",    1, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0);

    add("collide",  0, 2'b00, 2'b00, 2, 2'b00, 2'b00, 2'b00, 0);
    add("collide",  1, 2'b11, 2'b00, 2, 2'b11, 2'b10, 2'b00, 0);
    add("collide",  1, 2'b01, 2'b00, 2, 2'b01, 2'b01, 2'b10, 1);
    add("collide",  1, 2'b00, 2'b00, 2, 2'b00, 2'b00, 2'b01, 1);

    add("b2b",      0, 2'b11, 2'b10, 2, 2'b11, 2'b00, 2'b00, 0);
    add("b2b",      1, 2'b11, 2'b10, 2, 2'b11, 2'b10, 2'b00, 0);
    add("b2b",      1, 2'b11, 2'b10, 2, 2'b11, 2'b10, 2'b00, 1);
    add("b2b",      1, 2'b11, 2'b10, 2, 2'b01, 2'b01, 2'b10, 1);
    add("b2b",      1, 2'b11, 2'b10, 2, 2'b10, 2'b10, 2'b01, 1);
    add("b2b",      1, 2'b11, 2'b10, 2, 2'b11, 2'b10, 2'b00, 1);
    add("b2b",      1, 2'b11, 2'b10, 2, 2'b01, 2'b01, 2'b10, 1);
    add("b2b",      1, 2'b00, 2'b00, 2, 2'b00, 2'b00, 2'b01, 1);
    add("b2b",      1, 2'b00, 2'b00, 2, 2'b00, 2'b00, 2'b00, 0);

    add("drop",     0, 2'b00, 2'b00, 3, 2'b00, 2'b00, 2'b00, 0);
    add("drop",     1, 2'b01, 2'b00, 3, 2'b01, 2'b01, 2'b00, 0);
    add("drop",     1, 2'b00, 2'b00, 3, 2'b01, 2'b01, 2'b00, 1);
    add("drop",     1, 2'b00, 2'b00, 3, 2'b01, 2'b01, 2'b00, 1);
    add("drop",     1, 2'b00, 2'b00, 3, 2'b01, 2'b01, 2'b00, 1);
    add("drop",     1, 2'b00, 2'b00, 3, 2'b00, 2'b00, 2'b01, 1);
    add("drop",     1, 2'b00, 2'b00, 3, 2'b00, 2'b00, 2'b00, 0);

    add("rst_mid",  0, 2'b00, 2'b00, 3, 2'b00, 2'b00, 2'b00, 0);
    add("rst_mid",  1, 2'b01, 2'b00, 3, 2'b01, 2'b01, 2'b00, 0);
    add("rst_mid",  1, 2'b01, 2'b00, 3, 2'b01, 2'b01, 2'b00, 1);
    add("rst_mid",  0, 2'b01, 2'b00, 3, 2'b01, 2'b00, 2'b00, 0);
    add("rst_mid",  1, 2'b01, 2'b00, 3, 2'b01, 2'b01, 2'b00, 0);
    add("rst_mid",  1, 2'b01, 2'b00, 3, 2'b01, 2'b01, 2'b00, 1);
    add("rst_mid",  1, 2'b01, 2'b00, 3, 2'b01, 2'b01, 2'b00, 1);
    add("rst_mid",  1, 2'b01, 2'b00, 3, 2'b01, 2'b01, 2'b00, 1);
    add("rst_mid",  1, 2'b01, 2'b00, 3, 2'b00, 2'b00, 2'b01, 1);
    add("rst_mid",  1, 2'b00, 2'b00, 3, 2'b00, 2'b00, 2'b00, 0);

    add("rst_stall", 0, 2'b11, 2'b11, 2, 2'b11, 2'b00, 2'b00, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].rst_n, tbl[i].req, tbl[i].we);
      chk({tbl[i].nm, "_stall"}, tbl[i].inst, stall_o[tbl[i].inst], tbl[i].e_stall);
      chk({tbl[i].nm, "_grant"}, tbl[i].inst, grant_o[tbl[i].inst], tbl[i].e_grant);
      chk({tbl[i].nm, "_done"},  tbl[i].inst, done_o[tbl[i].inst],  tbl[i].e_done);
      chk({tbl[i].nm, "_busy"},  tbl[i].inst, {1'b0, busy_o[tbl[i].inst]}, {1'b0, tbl[i].e_busy});
      tick();
    end

    // Random traffic: requests mostly held, occasional drops and resets.
    begin
      logic [1:0] rq;
      logic [1:0] w;
      logic       r;
      rq = 2'b00;
      for (int n = 0; n < 800; n++) begin
        if ($urandom_range(0, 3) == 0) rq = 2'($urandom_range(0, 3));
        w = 2'($urandom_range(0, 3));
        r = ($urandom_range(0, 49) != 0);
        apply(r, rq, w);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
